// File: rtl/sync_fifo_reader.sv
// Read-side engine for the synchronous FIFO: paces pops against the lagging
// empty flag and presents popped words on a framed valid/ready stream.
module sync_fifo_reader #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 fifo_rd_en,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_last,
    output logic [CNT_WIDTH-1:0] xfer_count
);

    localparam int            BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    logic [WIDTH-1:0]     head_q, head_d;
    logic [WIDTH-1:0]     skid_q, skid_d;
    logic [1:0]           occ_q, occ_d;
    logic                 inflight_q, inflight_d;
    logic                 rd_prev_q;
    logic                 armed_q;
    logic [BW-1:0]        beat_q, beat_d;
    logic [CNT_WIDTH-1:0] xfer_q, xfer_d;
    logic                 hs;
    logic                 rd;

    always_comb begin
        head_d     = head_q;
        skid_d     = skid_q;
        beat_d     = beat_q;
        xfer_d     = xfer_q;
        hs         = (occ_q != 2'd0) && m_ready;
        // armed_q masks the first post-reset cycle, where the FIFO's empty flag is not yet valid
        rd         = en && !fifo_empty && !rd_prev_q && armed_q &&
                     ((occ_q + {1'b0, inflight_q}) < 2'd2);
        inflight_d = rd;
        occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, hs};

        if (hs) begin
            if (occ_q == 2'd2) begin
                head_d = skid_q;
                if (inflight_q) begin
                    skid_d = fifo_data;
                end
            end else if (inflight_q) begin
                head_d = fifo_data;
            end
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
            xfer_d = xfer_q + CNT_WIDTH'(1);
        end else if (inflight_q) begin
            if (occ_q == 2'd0) begin
                head_d = fifo_data;
            end else begin
                skid_d = fifo_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q     <= '0;
            skid_q     <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            rd_prev_q  <= 1'b0;
            armed_q    <= 1'b0;
            beat_q     <= '0;
            xfer_q     <= '0;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            rd_prev_q  <= rd;
            armed_q    <= 1'b1;
            beat_q     <= beat_d;
            xfer_q     <= xfer_d;
        end
    end

    assign fifo_rd_en = rd;
    assign m_valid    = (occ_q != 2'd0);
    assign m_data     = head_q;
    assign m_last     = m_valid && (beat_q == LAST_BEAT);
    assign xfer_count = xfer_q;

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Bench for sync_fifo_reader: two instances (bursts of 4 and 3) fed by a FIFO model
// with a lagging empty flag, checked against the written word order and burst rule.
module tb_sync_fifo_reader;

    localparam int BL0 = 4;
    localparam int BL1 = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        en [2];
    logic        fifo_empty [2];
    logic        fifo_rd_en [2];
    logic        m_valid [2];
    logic        m_ready [2];
    logic        m_last [2];
    logic [7:0]  fifo_data [2];
    logic [7:0]  m_data [2];
    logic [15:0] xfer_count [2];

    always #5 clk = ~clk;

    sync_fifo_reader #(.WIDTH(8), .BURST_LEN(BL0), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .reset(reset), .en(en[0]), .fifo_empty(fifo_empty[0]),
        .fifo_data(fifo_data[0]), .fifo_rd_en(fifo_rd_en[0]), .m_valid(m_valid[0]),
        .m_ready(m_ready[0]), .m_data(m_data[0]), .m_last(m_last[0]),
        .xfer_count(xfer_count[0])
    );

    sync_fifo_reader #(.WIDTH(8), .BURST_LEN(BL1), .CNT_WIDTH(16)) dut1 (
        .clk(clk), .reset(reset), .en(en[1]), .fifo_empty(fifo_empty[1]),
        .fifo_data(fifo_data[1]), .fifo_rd_en(fifo_rd_en[1]), .m_valid(m_valid[1]),
        .m_ready(m_ready[1]), .m_data(m_data[1]), .m_last(m_last[1]),
        .xfer_count(xfer_count[1])
    );

    // FIFO model: empty is registered from the pointers, so it lags them by one edge
    logic [7:0] mem [2][64];
    int         wr_ptr [2];
    int         rd_ptr [2];
    int         underflow [2];
    logic       wr_req [2];
    logic [7:0] wr_data [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                wr_ptr[k]     <= 0;
                rd_ptr[k]     <= 0;
                fifo_empty[k] <= 1'b0;
                fifo_data[k]  <= 8'h00;
            end else begin
                fifo_empty[k] <= (wr_ptr[k] == rd_ptr[k]);
                if (wr_req[k]) begin
                    mem[k][wr_ptr[k] % 64] <= wr_data[k];
                    wr_ptr[k] <= wr_ptr[k] + 1;
                end
                if (fifo_rd_en[k] && !fifo_empty[k]) begin
                    if (rd_ptr[k] >= wr_ptr[k]) underflow[k] <= underflow[k] + 1;
                    fifo_data[k] <= mem[k][rd_ptr[k] % 64];
                    rd_ptr[k]    <= rd_ptr[k] + 1;
                end
            end
        end
    end

    int         passed = 0;
    int         fails  = 0;
    int         total  = 0;
    int         cyc    = 0;
    int         rd_cnt [2];
    int         consec [2];
    int         stab [2];
    int         hs_idx [2];
    int         last_cnt [2];
    int         written [2];
    int         first_rd [2];
    int         first_v [2];
    logic       rd_prev [2];
    logic       mvrd [2];
    logic       hold [2];
    logic [7:0] hold_d [2];
    logic       hold_l [2];
    logic [7:0] wr_log [2][64];

    function automatic int bl(input int k);
        return (k == 0) ? BL0 : BL1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe the current cycle just after the falling edge, then advance.
    task automatic tick();
        #1;
        cyc++;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                if (fifo_rd_en[k]) begin
                    rd_cnt[k]++;
                    if (rd_prev[k]) consec[k]++;
                    if (first_rd[k] < 0) first_rd[k] = cyc;
                end
                if (m_valid[k] && first_v[k] < 0) first_v[k] = cyc;
                if (hold[k] && (!m_valid[k] || m_data[k] !== hold_d[k] || m_last[k] !== hold_l[k]))
                    stab[k]++;
                if (m_valid[k] && m_ready[k]) begin
                    if (hs_idx[k] < written[k]) begin
                        chk($sformatf("data[%0d] word %0d", k, hs_idx[k]), m_data[k], wr_log[k][hs_idx[k]]);
                        chk($sformatf("last[%0d] word %0d", k, hs_idx[k]), m_last[k],
                            ((hs_idx[k] % bl(k)) == bl(k) - 1) ? 1 : 0);
                    end else begin
                        chk($sformatf("extra_word[%0d]", k), hs_idx[k] + 1, written[k]);
                    end
                    if (m_last[k]) last_cnt[k]++;
                    hs_idx[k]++;
                end
                hold[k]    = m_valid[k] && !m_ready[k];
                hold_d[k]  = m_data[k];
                hold_l[k]  = m_last[k];
                rd_prev[k] = fifo_rd_en[k];
                mvrd[k]    = m_valid[k] && fifo_rd_en[k];
            end
        end
        @(negedge clk);
    endtask

    task automatic push(input int k, input logic [7:0] d);
        wr_req[k]  = 1'b1;
        wr_data[k] = d;
        wr_log[k][written[k]] = d;
        written[k]++;
        tick();
        wr_req[k] = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wr_req[k]  = 1'b0;
            en[k]      = 1'b0;
            m_ready[k] = 1'b0;
            rd_cnt[k]  = 0;
            hs_idx[k]  = 0;
            last_cnt[k] = 0;
            written[k] = 0;
            first_rd[k] = -1;
            first_v[k] = -1;
            rd_prev[k] = 1'b0;
            mvrd[k]    = 1'b0;
            hold[k]    = 1'b0;
        end
        tick();
        #1;
        chk({tag, "_rd_en"},  fifo_rd_en[0], 0);
        chk({tag, "_valid"},  m_valid[0], 0);
        chk({tag, "_data"},   m_data[0], 0);
        chk({tag, "_last"},   m_last[0], 0);
        chk({tag, "_xfer"},   xfer_count[0], 0);
        chk({tag, "_valid1"}, m_valid[1], 0);
        chk({tag, "_xfer1"},  xfer_count[1], 0);
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int n;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            en[k] = 1'b0; m_ready[k] = 1'b0; wr_req[k] = 1'b0; wr_data[k] = 8'h00;
            consec[k] = 0; stab[k] = 0;
        end
        @(negedge clk);

        // Basic order
        do_reset("rst");
        en[0] = 1'b1; m_ready[0] = 1'b1;
        push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h44);
        repeat (30) tick();
        chk("basic_xfer", xfer_count[0], 4);
        chk("basic_words", hs_idx[0], 4);
        chk("basic_lasts", last_cnt[0], 1);
        chk("basic_latency", first_v[0] - first_rd[0], 2);
        $display("basic: %0d words, xfer_count=%0h", hs_idx[0], xfer_count[0]);

        // Post-reset guard
        do_reset("guard_rst");
        en[0] = 1'b1; m_ready[0] = 1'b1;
        repeat (10) tick();
        chk("guard_no_rd", rd_cnt[0], 0);
        chk("guard_no_valid", m_valid[0], 0);
        push(0, 8'hA5);
        repeat (12) tick();
        chk("guard_one_pop", rd_cnt[0], 1);
        chk("guard_one_word", hs_idx[0], 1);
        $display("guard: pops=%0d words=%0d", rd_cnt[0], hs_idx[0]);

        // Backpressure
        do_reset("bp_rst");
        en[0] = 1'b1;
        for (int i = 0; i < 6; i++) push(0, 8'($urandom));
        repeat (14) tick();
        chk("bp_pops", rd_ptr[0], 2);
        chk("bp_valid", m_valid[0], 1);
        chk("bp_head", m_data[0], wr_log[0][0]);
        m_ready[0] = 1'b1;
        repeat (30) tick();
        chk("bp_words", hs_idx[0], 6);
        chk("bp_xfer", xfer_count[0], 6);
        $display("backpressure: words=%0d", hs_idx[0]);

        // Burst framing on the 3-beat instance with toggling ready
        do_reset("burst_rst");
        en[1] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            m_ready[1] = (i % 2 == 0);
            if (i < 7) push(1, 8'($urandom));
            else tick();
        end
        chk("burst_words", hs_idx[1], 7);
        chk("burst_lasts", last_cnt[1], 2);
        chk("burst_xfer", xfer_count[1], 7);
        m_ready[1] = 1'b1;
        push(1, 8'($urandom)); push(1, 8'($urandom));
        repeat (20) tick();
        chk("burst_resume_lasts", last_cnt[1], 3);
        $display("burst: words=%0d lasts=%0d", hs_idx[1], last_cnt[1]);

        // Enable gating
        do_reset("en_rst");
        en[0] = 1'b1; m_ready[0] = 1'b1;
        push(0, 8'($urandom));
        n = 0;
        do begin tick(); n++; end while (!rd_prev[0] && n < 30);
        chk("en_first_pop", rd_prev[0], 1);
        en[0] = 1'b0;
        for (int i = 0; i < 3; i++) push(0, 8'($urandom));
        repeat (12) tick();
        chk("en_gated_pops", rd_cnt[0], 1);
        chk("en_gated_words", hs_idx[0], 1);
        en[0] = 1'b1;
        repeat (30) tick();
        chk("en_resume_words", hs_idx[0], 4);
        chk("en_resume_xfer", xfer_count[0], 4);
        $display("enable: words=%0d", hs_idx[0]);

        // Reset while one word is buffered and another is in flight
        do_reset("mid_pre");
        en[0] = 1'b1;
        for (int i = 0; i < 3; i++) push(0, 8'($urandom));
        n = 0;
        while (!mvrd[0] && n < 30) begin tick(); n++; end
        chk("mid_reach_state", mvrd[0], 1);
        do_reset("mid_rst");
        $display("mid-reset: outputs checked");

        // Random soak against the ordered-stream model
        do_reset("soak_rst");
        for (int i = 0; i < 300; i++) begin
            en[0]      = ($urandom % 4) != 0;
            m_ready[0] = ($urandom % 2) != 0;
            if (($urandom % 3) == 0 && written[0] < 60) push(0, 8'($urandom));
            else tick();
        end
        en[0] = 1'b1; m_ready[0] = 1'b1;
        repeat (200) tick();
        chk("soak_words", hs_idx[0], written[0]);
        chk("soak_xfer", xfer_count[0], written[0]);
        $display("soak: written=%0d delivered=%0d", written[0], hs_idx[0]);

        chk("no_consecutive_rd0", consec[0], 0);
        chk("no_consecutive_rd1", consec[1], 0);
        chk("hold_stable0", stab[0], 0);
        chk("hold_stable1", stab[1], 0);
        chk("no_underflow0", underflow[0], 0);
        chk("no_underflow1", underflow[1], 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
